// File: rtl/mnist_frame_loader_if.sv
// rtl/mnist_frame_loader_if.sv - host beat input and core replay/response signals
interface mnist_frame_loader_if #(
    parameter int BEAT_W     = 8,
    parameter int CLASS_BITS = 4
);
    logic [BEAT_W-1:0]     pix_in;
    logic                  pix_valid;
    logic                  sof;
    logic                  core_start;
    logic [BEAT_W-1:0]     core_pix;
    logic                  core_done;
    logic [CLASS_BITS-1:0] core_pred;

    // Environment side: host pixel source plus the core's response
    modport master (
        output pix_in, pix_valid, sof, core_done, core_pred,
        input  core_start, core_pix
    );

    // Loader side
    modport slave (
        input  pix_in, pix_valid, sof, core_done, core_pred,
        output core_start, core_pix
    );
endinterface

// File: rtl/mnist_frame_loader.sv
// rtl/mnist_frame_loader.sv - buffers a host-paced frame, replays it to the core, latches the prediction
module mnist_frame_loader #(
    parameter int PIX_BITS       = 2,
    parameter int PIX_PER_BEAT   = 4,
    parameter int N_PIXELS       = 64,
    parameter int CLASS_BITS     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mnist_frame_loader_if.slave   io,
    input  logic                  clr_err,
    output logic [CLASS_BITS-1:0] result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  err_overrun,
    output logic                  err_sync,
    output logic                  err_timeout
);
    localparam int BEAT_W = PIX_BITS * PIX_PER_BEAT;
    localparam int BEATS  = N_PIXELS / PIX_PER_BEAT;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, WAIT} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  beat_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [BEAT_W-1:0] frame_buf [BEATS];

    logic store_first, store_next, capture;
    logic set_sync, set_ovr, set_to;

    // beat_cnt is the write index while loading and the replay index while streaming
    assign busy          = (state != IDLE);
    assign io.core_start = (state == STREAM) && (beat_cnt == '0);
    assign io.core_pix   = (state == STREAM) ? frame_buf[beat_cnt[IDX_W-1:0]] : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_n     = state;
        store_first = 1'b0;
        store_next  = 1'b0;
        capture     = 1'b0;
        set_sync    = 1'b0;
        set_ovr     = 1'b0;
        set_to      = 1'b0;
        case (state)
            IDLE: begin
                if (io.pix_valid && io.sof) begin
                    store_first = 1'b1;
                    state_n     = (BEATS == 1) ? STREAM : LOAD;
                end else if (io.pix_valid) begin
                    set_sync = 1'b1;
                end
            end
            LOAD: begin
                if (io.pix_valid && io.sof) begin
                    store_first = 1'b1;
                end else if (io.pix_valid) begin
                    store_next = 1'b1;
                    if (beat_cnt == LAST_BEAT) state_n = STREAM;
                end
            end
            STREAM: begin
                set_ovr = io.pix_valid;
                if (beat_cnt == LAST_BEAT) state_n = WAIT;
            end
            WAIT: begin
                set_ovr = io.pix_valid;
                // core_done in the last watchdog cycle still counts as a result
                if (io.core_done) begin
                    capture = 1'b1;
                    state_n = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    set_to  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame buffer, counters, result latch and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BEATS; i++) frame_buf[i] <= '0;
            beat_cnt     <= '0;
            wd_cnt       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err_overrun  <= 1'b0;
            err_sync     <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (store_first) begin
                frame_buf[0] <= io.pix_in;
                beat_cnt     <= CNT_W'(1);
                result_valid <= 1'b0;
            end else if (store_next) begin
                frame_buf[beat_cnt[IDX_W-1:0]] <= io.pix_in;
                beat_cnt <= beat_cnt + 1'b1;
            end else if (state == STREAM) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            // Replay always starts from beat 0, whichever path led into STREAM
            if (state_n == STREAM && state != STREAM) beat_cnt <= '0;

            wd_cnt <= (state == WAIT && state_n == WAIT) ? wd_cnt + 1'b1 : '0;

            if (capture) begin
                result       <= io.core_pred;
                result_valid <= 1'b1;
            end

            // A flag raised in the same cycle as clr_err survives the clear
            err_overrun <= (err_overrun & ~clr_err) | set_ovr;
            err_sync    <= (err_sync    & ~clr_err) | set_sync;
            err_timeout <= (err_timeout & ~clr_err) | set_to;
        end
    end
endmodule

// File: tb/tb_mnist_frame_loader.sv
// tb/tb_mnist_frame_loader.sv - randomized self-checking bench for three loader configurations
module tb_mnist_frame_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_err = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-DUT stimulus and observed outputs; index 0: BEATS=16, 1: BEATS=4 / timeout 32, 2: BEATS=1
    logic [7:0] pin [3];
    logic       pv [3];
    logic       sf [3];
    logic       cd [3];
    logic [3:0] cp [3];
    logic [7:0] opix [3];
    logic       ostart [3];
    logic [3:0] ores [3];
    logic       orv [3];
    logic       obusy [3];
    logic       eo [3];
    logic       es [3];
    logic       et [3];

    // Reference frame: the beats the loader should replay, built from the sof/append rule
    logic [7:0] model_q [$];

    mnist_frame_loader_if #(.BEAT_W(8), .CLASS_BITS(4)) if0 ();
    mnist_frame_loader_if #(.BEAT_W(4), .CLASS_BITS(4)) if1 ();
    mnist_frame_loader_if #(.BEAT_W(8), .CLASS_BITS(4)) if2 ();

    assign if0.pix_in = pin[0];      assign if1.pix_in = pin[1][3:0];  assign if2.pix_in = pin[2];
    assign if0.pix_valid = pv[0];    assign if1.pix_valid = pv[1];     assign if2.pix_valid = pv[2];
    assign if0.sof = sf[0];          assign if1.sof = sf[1];           assign if2.sof = sf[2];
    assign if0.core_done = cd[0];    assign if1.core_done = cd[1];     assign if2.core_done = cd[2];
    assign if0.core_pred = cp[0];    assign if1.core_pred = cp[1];     assign if2.core_pred = cp[2];
    assign opix[0] = if0.core_pix;   assign opix[1] = {4'b0, if1.core_pix}; assign opix[2] = if2.core_pix;
    assign ostart[0] = if0.core_start; assign ostart[1] = if1.core_start; assign ostart[2] = if2.core_start;

    mnist_frame_loader #(.PIX_BITS(2), .PIX_PER_BEAT(4), .N_PIXELS(64), .CLASS_BITS(4), .TIMEOUT_CYCLES(4096)) d0 (
        .clk(clk), .rst_n(rst_n), .io(if0.slave), .clr_err(clr_err), .result(ores[0]), .result_valid(orv[0]),
        .busy(obusy[0]), .err_overrun(eo[0]), .err_sync(es[0]), .err_timeout(et[0]));
    mnist_frame_loader #(.PIX_BITS(2), .PIX_PER_BEAT(2), .N_PIXELS(8), .CLASS_BITS(4), .TIMEOUT_CYCLES(32)) d1 (
        .clk(clk), .rst_n(rst_n), .io(if1.slave), .clr_err(clr_err), .result(ores[1]), .result_valid(orv[1]),
        .busy(obusy[1]), .err_overrun(eo[1]), .err_sync(es[1]), .err_timeout(et[1]));
    mnist_frame_loader #(.PIX_BITS(2), .PIX_PER_BEAT(4), .N_PIXELS(4), .CLASS_BITS(4), .TIMEOUT_CYCLES(4096)) d2 (
        .clk(clk), .rst_n(rst_n), .io(if2.slave), .clr_err(clr_err), .result(ores[2]), .result_valid(orv[2]),
        .busy(obusy[2]), .err_overrun(eo[2]), .err_sync(es[2]), .err_timeout(et[2]));

    function automatic int nb(int d);
        return (d == 0) ? 16 : (d == 1) ? 4 : 1;
    endfunction

    function automatic int tmo(int d);
        return (d == 1) ? 32 : 4096;
    endfunction

    function automatic logic [7:0] msk(int d, logic [7:0] v);
        return (d == 1) ? (v & 8'h0F) : v;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(int d, string tag);
        check(tag, {ostart[d], opix[d], ores[d], orv[d], obusy[d], eo[d], es[d], et[d]}, 32'd0);
    endtask

    task automatic send_beat(int d, logic [7:0] v, bit s);
        pin[d] = v; pv[d] = 1'b1; sf[d] = s;
        step();
        pv[d] = 1'b0; sf[d] = 1'b0;
        if (s) model_q.delete();
        model_q.push_back(msk(d, v));
    endtask

    task automatic gap(int d, int gapmax);
        int n;
        n = $urandom_range(gapmax, 0);
        repeat (n) begin
            step();
            check("load_hold", {obusy[d], ostart[d]}, 2'b10);
        end
    endtask

    // pre > 0 sends that many beats of a discarded frame before the real sof
    task automatic load_frame(int d, int pre, int gapmax, logic [7:0] base);
        for (int i = 0; i < pre; i++) begin
            if (i > 0) gap(d, gapmax);
            send_beat(d, 8'($urandom), i == 0);
        end
        for (int k = 0; k < nb(d); k++) begin
            if (k > 0 || pre > 0) gap(d, gapmax);
            send_beat(d, base + 8'(k), k == 0);
        end
    endtask

    // stray_k >= 0 injects an unsolicited beat during that replay cycle
    task automatic replay(int d, int stray_k);
        for (int k = 0; k < nb(d); k++) begin
            check("core_start", ostart[d], (k == 0) ? 1 : 0);
            check("core_pix", opix[d], model_q[k]);
            if (k == stray_k) begin
                pin[d] = 8'($urandom); pv[d] = 1'b1;
            end
            step();
            pv[d] = 1'b0;
        end
        check("wait_busy", obusy[d], 1);
        check("pix_idle", {ostart[d], opix[d]}, 0);
    endtask

    // n is the WAIT cycle (0-based) in which done is raised; n >= timeout means never
    task automatic wait_core(int d, int n, logic [3:0] pred);
        if (n < tmo(d)) begin
            repeat (n) step();
            check("rv_in_wait", orv[d], 0);
            cd[d] = 1'b1; cp[d] = pred;
            step();
            cd[d] = 1'b0;
            check("result", ores[d], pred);
            check("result_valid", orv[d], 1);
            check("idle_after", {obusy[d], et[d]}, 2'b00);
        end else begin
            repeat (tmo(d) - 1) step();
            check("pre_timeout", {obusy[d], et[d]}, 2'b10);
            step();
            check("timeout", {obusy[d], et[d], orv[d]}, 3'b010);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0t expected < 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            pin[d] = '0; pv[d] = 1'b0; sf[d] = 1'b0; cd[d] = 1'b0; cp[d] = '0;
        end
        repeat (3) step();
        for (int d = 0; d < 3; d++) chk_zero(d, "reset_state");
        rst_n = 1'b1;
        step();

        // Nominal frame with random host gaps
        load_frame(0, 0, 3, 8'h10);
        replay(0, -1);
        wait_core(0, 100, 4'd7);
        check("t1_errs", {eo[0], es[0], et[0]}, 0);

        // Resync: 6 beats of an abandoned frame, then a full frame
        load_frame(0, 6, 3, 8'h40);
        replay(0, -1);
        wait_core(0, 20, 4'd5);
        check("t2_errs", {eo[0], es[0], et[0]}, 0);

        // Stray beats in IDLE and during replay, then clear
        pin[0] = 8'hAA; pv[0] = 1'b1;
        step();
        pv[0] = 1'b0;
        check("sync_err", {es[0], obusy[0]}, 2'b10);
        load_frame(0, 0, 2, 8'h80);
        replay(0, 5);
        check("overrun_err", eo[0], 1);
        wait_core(0, 10, 4'd4);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_err", {eo[0], es[0]}, 2'b00);
        pv[0] = 1'b1; clr_err = 1'b1;
        step();
        pv[0] = 1'b0; clr_err = 1'b0;
        check("set_beats_clear", es[0], 1);
        cd[0] = 1'b1; cp[0] = 4'h9;
        step();
        cd[0] = 1'b0;
        check("done_ignored", {ores[0], orv[0], obusy[0]}, {4'h4, 1'b1, 1'b0});
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Result holds through idle, cleared by the next sof
        load_frame(0, 0, 1, 8'($urandom));
        replay(0, -1);
        wait_core(0, 30, 4'd3);
        repeat (50) step();
        check("result_hold", {ores[0], orv[0]}, {4'h3, 1'b1});
        send_beat(0, 8'h55, 1'b1);
        check("rv_cleared", {orv[0], obusy[0]}, 2'b01);

        // Reset after beat 9 of a load, then during WAIT, then a clean frame
        for (int k = 1; k < 9; k++) send_beat(0, 8'(k), 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "rst_mid_load");
        step();
        rst_n = 1'b1;
        load_frame(0, 0, 2, 8'h20);
        replay(0, -1);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk_zero(0, "rst_mid_wait");
        step();
        rst_n = 1'b1;
        load_frame(0, 0, 3, 8'h10);
        replay(0, -1);
        wait_core(0, 100, 4'd7);
        check("t6_errs", {eo[0], es[0], et[0]}, 0);

        // BEATS=4 with a 32-cycle watchdog: timeout, then done on the last WAIT cycle
        load_frame(1, 2, 2, 8'h03);
        replay(1, -1);
        wait_core(1, 1000, 4'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t4_clr", et[1], 0);
        load_frame(1, 0, 2, 8'h0A);
        replay(1, 2);
        wait_core(1, 31, 4'd6);
        check("t4_overrun", eo[1], 1);

        // BEATS=1: sof beat goes straight to replay
        load_frame(2, 0, 0, 8'hC3);
        replay(2, -1);
        wait_core(2, 5, 4'd2);
        load_frame(2, 0, 0, 8'h3C);
        replay(2, 0);
        check("b1_overrun", eo[2], 1);
        wait_core(2, 0, 4'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
